// File: rtl/cbd_sampler_if.sv
// Stream and control bundle between the CBD sampler, the sponge side and the
// polynomial RAM side.
interface cbd_sampler_if #(
  parameter int IN_W  = 64,
  parameter int LANES = 2
);
  logic                  start;
  logic                  eta3;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, eta3, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done
  );

  modport master (
    output start, eta3, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/cbd_sampler.sv
// Centred-binomial sampler (eta=2 or eta=3 per polynomial): packs a sponge
// bit stream into LANES coefficients per beat, reduced into [0, Q).
//
// state | meaning
// IDLE  | waiting for start; buffer and counters cleared
// RUN   | accepting sponge words and emitting coefficient beats
// DONE  | one-cycle done pulse after the final beat handshake
module cbd_sampler #(
  parameter int IN_W  = 64,
  parameter int LANES = 2,
  parameter int N     = 256,
  parameter int Q     = 3329
) (
  input logic         clk,
  input logic         rst_n,
  cbd_sampler_if.slave bus
);
  localparam int BUF_W  = 2 * IN_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int WORDS2 = (N * 4) / IN_W;
  localparam int WORDS3 = (N * 6) / IN_W;
  localparam int WCNT_W = $clog2(WORDS3 + 1);
  localparam int BEATS  = N / LANES;
  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam int OUT_W  = 16 * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   bits_q, bits_d, bits_shifted;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_base, need;
  logic [WCNT_W-1:0]  words_rcvd_q, words_target;
  logic [BCNT_W-1:0]  beats_left_q;
  logic               eta3_q;
  logic [OUT_W-1:0]   out_data_q, lanes_d;
  logic               out_valid_q, out_last_q;
  logic               in_ready, start_ok, accept, load, last_hs;
  logic               busy, done;

  // 6-bit window; for eta=2 only the low 4 bits carry data.
  function automatic logic [15:0] cbd_coef(input logic [5:0] bits, input logic is_eta3);
    logic [1:0] a, b;
    if (is_eta3) begin
      a = 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
      b = 2'(bits[3]) + 2'(bits[4]) + 2'(bits[5]);
    end else begin
      a = 2'(bits[0]) + 2'(bits[1]);
      b = 2'(bits[2]) + 2'(bits[3]);
    end
    if (a >= b) return 16'(a - b);
    else        return 16'(Q) - 16'(b - a);
  endfunction

  assign need         = eta3_q ? FILL_W'(6 * LANES) : FILL_W'(4 * LANES);
  assign words_target = eta3_q ? WCNT_W'(WORDS3) : WCNT_W'(WORDS2);

  // in_ready depends on registered state only, so no path from out_ready.
  assign in_ready = (state_q == RUN) && (words_rcvd_q < words_target) &&
                    (fill_q <= FILL_W'(BUF_W - IN_W));
  assign accept   = in_ready && bus.in_valid;
  assign load     = (state_q == RUN) && (fill_q >= need) && (beats_left_q != '0) &&
                    (!out_valid_q || bus.out_ready);
  assign last_hs  = out_valid_q && out_last_q && bus.out_ready;
  assign start_ok = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_hs) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Consume first, then append the new word just above the remaining fill.
  always_comb begin
    bits_shifted = load ? (bits_q >> need) : bits_q;
    fill_base    = load ? (fill_q - need) : fill_q;
    bits_d       = bits_shifted;
    fill_d       = fill_base;
    if (accept) begin
      bits_d = bits_shifted | (BUF_W'(bus.in_data) << fill_base);
      fill_d = fill_base + FILL_W'(IN_W);
    end
  end

  always_comb begin
    lanes_d = '0;
    for (int j = 0; j < LANES; j++) begin
      lanes_d[16*j +: 16] = cbd_coef(eta3_q ? bits_q[6*j +: 6] : {2'b00, bits_q[4*j +: 4]},
                                     eta3_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q       <= '0;
      fill_q       <= '0;
      words_rcvd_q <= '0;
      beats_left_q <= '0;
      eta3_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else if (start_ok) begin
      bits_q       <= '0;
      fill_q       <= '0;
      words_rcvd_q <= '0;
      beats_left_q <= BCNT_W'(BEATS);
      eta3_q       <= bus.eta3;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else if (state_q == DONE) begin
      bits_q       <= '0;
      fill_q       <= '0;
      words_rcvd_q <= '0;
    end else if (state_q == RUN) begin
      bits_q <= bits_d;
      fill_q <= fill_d;
      if (accept) words_rcvd_q <= words_rcvd_q + WCNT_W'(1);
      if (load) begin
        out_data_q   <= lanes_d;
        out_valid_q  <= 1'b1;
        out_last_q   <= (beats_left_q == BCNT_W'(1));
        beats_left_q <= beats_left_q - BCNT_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_cbd_sampler.sv
// Bench for cbd_sampler: directed polynomials checked beat-by-beat against a
// bit-level reference model of the centred-binomial rule.
module tb_cbd_sampler;
  localparam int IN_W  = 64;
  localparam int LANES = 2;
  localparam int N     = 256;
  localparam int Q     = 3329;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cbd_sampler_if #(.IN_W(IN_W), .LANES(LANES)) bus ();

  cbd_sampler #(.IN_W(IN_W), .LANES(LANES), .N(N), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] words [0:23];
  int          n_words;
  int          exp_coef [0:255];

  bit          mon_on = 1'b0;
  int          beat_idx, acc_words, first_in_cyc, first_ov_cyc, last_cyc;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic [31:0] got_beat [0:127];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: coefficient i = popcount(low eta bits) - popcount(next eta bits) mod Q.
  function automatic int model_coef(input int i, input bit mode);
    int eta, a, b, k;
    eta = mode ? 3 : 2;
    a = 0;
    b = 0;
    for (int t = 0; t < eta; t++) begin
      k = 2 * eta * i + t;
      a += int'(words[k / 64][k % 64]);
      k = 2 * eta * i + eta + t;
      b += int'(words[k / 64][k % 64]);
    end
    return (a >= b) ? (a - b) : (Q + a - b);
  endfunction

  task automatic build(input bit mode, input int pat);
    int p;
    n_words = mode ? 24 : 16;
    for (int w = 0; w < 24; w++) begin
      case (pat)
        0:       words[w] = 64'h3333_3333_3333_3333;
        1:       words[w] = 64'hCCCC_CCCC_CCCC_CCCC;
        2:       words[w] = (w == 0) ? 64'hF000_0000_0000_0000 : 64'h0;
        4:       words[w] = {$urandom, $urandom};
        default: words[w] = 64'h0;
      endcase
    end
    if (pat == 3) begin
      for (int k = 0; k < n_words * 64; k++) begin
        p = (k / 6) % 64;
        words[k / 64][k % 64] = 1'((p >> (k % 6)) & 1);
      end
    end
    for (int i = 0; i < N; i++) exp_coef[i] = model_coef(i, mode);
  endtask

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (bus.in_ready)
        chk(acc_words < n_words, "in_ready_after_last_word", acc_words, n_words);
      if (bus.in_valid && bus.in_ready) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        acc_words++;
      end
      if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (prev_stall) begin
        chk(bus.out_valid == 1'b1, "stall_valid_hold", bus.out_valid, 1);
        chk(bus.out_data == prev_data, "stall_data_hold", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk(beat_idx < N / LANES, "beat_overflow", beat_idx, N / LANES - 1);
        if (beat_idx < N / LANES) begin
          for (int j = 0; j < LANES; j++)
            chk(bus.out_data[16*j +: 16] == 16'(exp_coef[beat_idx * LANES + j]),
                $sformatf("coef_%0d", beat_idx * LANES + j),
                bus.out_data[16*j +: 16], exp_coef[beat_idx * LANES + j]);
          chk(bus.out_last == (beat_idx == N / LANES - 1), $sformatf("out_last_beat_%0d", beat_idx),
              bus.out_last, (beat_idx == N / LANES - 1));
          got_beat[beat_idx] = bus.out_data;
          if (beat_idx == N / LANES - 1) last_cyc = cyc;
        end
        beat_idx++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        chk(bus.done == 1'b1, "done_pulse", bus.done, 1);
        chk(bus.busy == 1'b1, "busy_in_done", bus.busy, 1);
      end else if (last_cyc >= 0 && cyc == last_cyc + 2) begin
        chk(bus.done == 1'b0, "done_clear", bus.done, 0);
        chk(bus.busy == 1'b0, "busy_clear", bus.busy, 0);
      end else begin
        chk(bus.done == 1'b0, "done_spurious", bus.done, 0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk(bus.in_ready  == 1'b0, {tag, "_in_ready"},  bus.in_ready, 0);
    chk(bus.out_valid == 1'b0, {tag, "_out_valid"}, bus.out_valid, 0);
    chk(bus.out_data  == '0,   {tag, "_out_data"},  bus.out_data, 0);
    chk(bus.out_last  == 1'b0, {tag, "_out_last"},  bus.out_last, 0);
    chk(bus.busy      == 1'b0, {tag, "_busy"},      bus.busy, 0);
    chk(bus.done      == 1'b0, {tag, "_done"},      bus.done, 0);
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_poly(input bit mode, input int pat, input bit stall, input bit poke);
    int  idx, cycles;
    bit  hs, seen_done;
    build(mode, pat);
    beat_idx     = 0;
    acc_words    = 0;
    first_in_cyc = -1;
    first_ov_cyc = -1;
    last_cyc     = -1;
    prev_stall   = 1'b0;
    mon_on       = 1'b1;
    bus.start = 1'b1;
    bus.eta3  = mode;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.eta3  = !mode;
    idx       = 0;
    cycles    = 0;
    seen_done = 1'b0;
    while (!seen_done && cycles < 3000) begin
      bus.in_valid  = (idx < n_words) && (!stall || ($urandom_range(0, 1) == 1));
      bus.in_data   = bus.in_valid ? words[idx] : 64'hDEAD_BEEF_DEAD_BEEF;
      bus.out_ready = !stall || ($urandom_range(0, 1) == 1);
      if (poke && cycles == 10) begin
        bus.start = 1'b1;
        bus.eta3  = !mode;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (cycles == 0) begin
        chk(bus.busy == 1'b1, "busy_after_start", bus.busy, 1);
        chk(bus.in_ready == 1'b1, "in_ready_after_start", bus.in_ready, 1);
      end
      hs = bus.in_valid && bus.in_ready;
      if (bus.done) seen_done = 1'b1;
      @(posedge clk); #1;
      if (hs) idx++;
      cycles++;
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk(seen_done, "done_within_budget", seen_done, 1);
    @(negedge clk);
    @(posedge clk); #1;
    mon_on = 1'b0;
    chk(beat_idx == N / LANES, "beat_count", beat_idx, N / LANES);
    chk(acc_words == n_words, "words_accepted", acc_words, n_words);
    chk(first_ov_cyc - first_in_cyc == 2, "first_beat_latency", first_ov_cyc - first_in_cyc, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  idx;
    bit  hs;
    bus.start     = 1'b0;
    bus.eta3      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_poly(1'b0, 0, 1'b0, 1'b0);
    chk(got_beat[0] == 32'h0002_0002, "pin_eta2_0x3_first", got_beat[0], 32'h0002_0002);
    chk(got_beat[127] == 32'h0002_0002, "pin_eta2_0x3_last", got_beat[127], 32'h0002_0002);

    run_poly(1'b0, 1, 1'b0, 1'b0);
    chk(got_beat[64] == {16'd3327, 16'd3327}, "pin_eta2_0xC", got_beat[64], {16'd3327, 16'd3327});

    run_poly(1'b1, 2, 1'b0, 1'b0);
    chk(got_beat[5] == 32'h0000_0002, "pin_eta3_straddle", got_beat[5], 32'h0000_0002);
    chk(got_beat[4] == 32'h0000_0000, "pin_eta3_zero", got_beat[4], 0);

    run_poly(1'b1, 3, 1'b0, 1'b0);
    chk(got_beat[3][31:16] == 16'd3, "pin_eta3_pat07", got_beat[3][31:16], 3);
    chk(got_beat[28][15:0] == 16'd3326, "pin_eta3_pat38", got_beat[28][15:0], 3326);

    run_poly(1'b1, 3, 1'b1, 1'b1);
    chk(got_beat[3][31:16] == 16'd3, "pin_stall_pat07", got_beat[3][31:16], 3);
    chk(got_beat[28][15:0] == 16'd3326, "pin_stall_pat38", got_beat[28][15:0], 3326);

    build(1'b0, 4);
    bus.start = 1'b1;
    bus.eta3  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      bus.in_valid  = (idx < n_words);
      bus.in_data   = words[idx % 24];
      bus.out_ready = 1'b1;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_poly(1'b0, 4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
